// File: rtl/gol_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gol_pkg: shared types and constants for the 8x8 Game of Life blocks        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } gol_state_t;

    localparam int GRID_W = 64;
    localparam logic [GRID_W-1:0] DEFAULT_SEED = 64'h4020_E000_0000_0000;

endpackage
`default_nettype wire

// File: rtl/gol_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gol_tick_gen: generation-rate divider, pulses tick on terminal count       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gol_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic start_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int               c_cnt_w = $clog2(TICK_DIV + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
        end
    end

    assign tick = en && !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/gol_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gol_sequencer: owns the current grid and commits generations from the      |
// | datapath on step, at the run rate, or replaces the grid on load. Rev 1.0   |
// +----------------------------------------------------------------------------+
module gol_sequencer
    import gol_pkg::*;
#(
    parameter int                GRID_W   = 64,
    parameter int                GEN_W    = 16,
    parameter int                TICK_DIV = 25_000_000,
    parameter logic [GRID_W-1:0] SEED     = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              start_n,
    input  logic              load,
    input  logic [GRID_W-1:0] seed_in,
    input  logic              run,
    input  logic              step,
    input  logic [GRID_W-1:0] next_grid,
    output logic [GRID_W-1:0] cur_grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              gen_tick,
    output logic              stable,
    output gol_state_t        state
);

    logic             w_tick_en;
    logic             w_tick_clr;
    logic             w_tick;
    logic             w_commit;
    logic             w_same;
    logic [GEN_W-1:0] w_gen_inc;
    logic             w_sat;

    // The divider only advances while actually running; anything else parks it at zero.
    assign w_tick_en  = (state == RUN) && run;
    assign w_tick_clr = load || !w_tick_en;

    gol_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .start_n (start_n),
        .clr     (w_tick_clr),
        .en      (w_tick_en),
        .tick    (w_tick)
    );

    assign w_commit  = !load && (((state == IDLE) && step) || w_tick);
    assign w_same    = (next_grid == cur_grid);
    assign w_gen_inc = gen_count + GEN_W'(1);
    assign w_sat     = &w_gen_inc;

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            cur_grid  <= SEED;
            gen_count <= '0;
            gen_tick  <= 1'b0;
            stable    <= 1'b0;
            state     <= IDLE;
        end else begin
            gen_tick <= 1'b0;
            if (load) begin
                cur_grid  <= seed_in;
                gen_count <= '0;
                stable    <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (run)  state <= RUN;
                    RUN:     if (!run) state <= IDLE;
                    HALT:    ;
                    default: state <= IDLE;
                endcase
                // A halting commit overrides the run/idle transition above.
                if (w_commit) begin
                    if (w_same) begin
                        stable <= 1'b1;
                        state  <= HALT;
                    end else begin
                        cur_grid  <= next_grid;
                        gen_count <= w_gen_inc;
                        gen_tick  <= 1'b1;
                        if (w_sat) state <= HALT;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gol_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gol_sequencer: scoreboard bench, reference Life datapath on next_grid   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gol_sequencer;
    import gol_pkg::*;

    localparam logic [63:0] c_seed    = 64'h4020_E000_0000_0000;
    localparam logic [63:0] c_glider1 = 64'h00A0_6040_0000_0000;
    localparam logic [63:0] c_block   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] c_blink   = 64'h0000_0000_0000_0007;

    typedef struct {
        logic [63:0] g;
        logic [15:0] n;
    } exp_t;

    logic        clk = 1'b0;
    logic        start_n, load, run, step, run3;
    logic [63:0] seed_in;
    logic [63:0] next_grid, cur_grid, next3, cur3;
    logic [15:0] gen_count;
    logic [2:0]  gen3;
    logic        gen_tick, stable, tick3, stable3;
    gol_state_t  state, state3;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    // Bounded 8x8 Life: cells outside the grid are dead.
    function automatic logic [63:0] life(input logic [63:0] g);
        logic [63:0] n;
        int          cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            cnt += int'(g[63 - ((r + dr) * 8 + (c + dc))]);
                if (g[63 - (r * 8 + c)]) n[63 - (r * 8 + c)] = (cnt == 2 || cnt == 3);
                else                     n[63 - (r * 8 + c)] = (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb next_grid = life(cur_grid);
    always_comb next3     = life(cur3);

    gol_sequencer #(.GRID_W(64), .GEN_W(16), .TICK_DIV(4), .SEED(c_seed)) dut (
        .clk(clk), .start_n(start_n), .load(load), .seed_in(seed_in), .run(run),
        .step(step), .next_grid(next_grid), .cur_grid(cur_grid), .gen_count(gen_count),
        .gen_tick(gen_tick), .stable(stable), .state(state)
    );

    gol_sequencer #(.GRID_W(64), .GEN_W(3), .TICK_DIV(4), .SEED(c_seed)) dut3 (
        .clk(clk), .start_n(start_n), .load(1'b0), .seed_in(64'h0), .run(run3),
        .step(1'b0), .next_grid(next3), .cur_grid(cur3), .gen_count(gen3),
        .gen_tick(tick3), .stable(stable3), .state(state3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (gen_tick) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit: got gen_count=%0d, expected no gen_tick", gen_count);
            end else begin
                e0 = q0.pop_front();
                chk("commit_grid", cur_grid, e0.g);
                chk("commit_gen", 64'(gen_count), 64'(e0.n));
            end
        end
        if (tick3) begin
            if (q3.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_commit3: got gen_count=%0d, expected no gen_tick", gen3);
            end else begin
                e3 = q3.pop_front();
                chk("commit3_grid", cur3, e3.g);
                chk("commit3_gen", 64'(gen3), 64'(e3.n[2:0]));
            end
        end
    end

    initial begin
        logic [63:0] exp_g;
        start_n = 1'b0; load = 1'b0; run = 1'b0; step = 1'b0; run3 = 1'b0;
        seed_in = '0;
        #12 start_n = 1'b1;
        cyc(1);
        chk("rst_grid", cur_grid, c_seed);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_state", 64'(state), 64'(IDLE));
        chk("rst_stable", 64'(stable), 64'd0);

        // Single step from the seed
        q0.push_back('{c_glider1, 16'd1});
        step = 1'b1; cyc(1); step = 1'b0;
        cyc(2);
        chk("step_tick_low", 64'(gen_tick), 64'd0);
        chk("step_state", 64'(state), 64'(IDLE));
        chk("step_gen", 64'(gen_count), 64'd1);

        // Free run: three commits, then idle quietly
        seed_in = c_seed; load = 1'b1; cyc(1); load = 1'b0;
        exp_g = c_seed;
        for (int i = 1; i <= 3; i++) begin
            exp_g = life(exp_g);
            q0.push_back('{exp_g, 16'(i)});
        end
        run = 1'b1; cyc(13); run = 1'b0; cyc(1);
        chk("run_gen", 64'(gen_count), 64'd3);
        chk("run_state_idle", 64'(state), 64'(IDLE));
        cyc(20);
        chk("idle_gen_held", 64'(gen_count), 64'd3);
        chk("idle_grid_held", cur_grid, exp_g);

        // Still life halts and ignores step/run
        seed_in = c_block; load = 1'b1; cyc(1); load = 1'b0;
        run = 1'b1; cyc(6);
        chk("still_stable", 64'(stable), 64'd1);
        chk("still_state", 64'(state), 64'(HALT));
        chk("still_gen", 64'(gen_count), 64'd0);
        chk("still_grid", cur_grid, c_block);
        step = 1'b1; cyc(1); step = 1'b0; cyc(6);
        chk("halt_state_held", 64'(state), 64'(HALT));
        chk("halt_grid_held", cur_grid, c_block);
        run = 1'b0; seed_in = c_seed; load = 1'b1; cyc(1); load = 1'b0;
        chk("reload_state", 64'(state), 64'(IDLE));
        chk("reload_stable", 64'(stable), 64'd0);
        chk("reload_grid", cur_grid, c_seed);

        // Load wins over step; run dropped on the terminal count commits nothing
        seed_in = c_blink; load = 1'b1; step = 1'b1; cyc(1); load = 1'b0; step = 1'b0;
        chk("loadstep_grid", cur_grid, c_blink);
        chk("loadstep_gen", 64'(gen_count), 64'd0);
        run = 1'b1; cyc(4); run = 1'b0; cyc(10);
        chk("rundrop_gen", 64'(gen_count), 64'd0);
        chk("rundrop_state", 64'(state), 64'(IDLE));
        chk("rundrop_grid", cur_grid, c_blink);

        // Asynchronous reset mid-run, right after a commit
        seed_in = c_seed; load = 1'b1; cyc(1); load = 1'b0;
        run = 1'b1; cyc(5);
        chk("pre_rst_gen", 64'(gen_count), 64'd1);
        #1 start_n = 1'b0;
        #1;
        chk("arst_grid", cur_grid, c_seed);
        chk("arst_gen", 64'(gen_count), 64'd0);
        chk("arst_state", 64'(state), 64'(IDLE));
        chk("arst_stable", 64'(stable), 64'd0);
        chk("arst_tick", 64'(gen_tick), 64'd0);
        run = 1'b0; cyc(1); start_n = 1'b1; cyc(1);
        chk("post_rst_state", 64'(state), 64'(IDLE));
        chk("post_rst_gen", 64'(gen_count), 64'd0);

        // Saturation with a 3-bit counter
        exp_g = c_seed;
        for (int i = 1; i <= 7; i++) begin
            exp_g = life(exp_g);
            q3.push_back('{exp_g, 16'(i)});
        end
        run3 = 1'b1; cyc(40);
        chk("sat_state", 64'(state3), 64'(HALT));
        chk("sat_stable", 64'(stable3), 64'd0);
        chk("sat_gen", 64'(gen3), 64'd7);
        chk("sat_grid", cur3, exp_g);
        run3 = 1'b0; cyc(2);

        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
